// File: rtl/toggle_pulse_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : toggle_pulse_gen_if
// Purpose  : Groups the push-button input and the toggle-request outputs of
//            toggle_pulse_gen into one bundle.
// Signals  : btn_in    - raw asynchronous button level, active-high
//            t_out     - one-cycle toggle-request pulse
//            btn_db    - debounced button level
//            press_cnt - wrapping count of t_out pulses issued
// Modports : master - drives the button and observes the results
//            slave  - the pulse generator itself
// Revision : 1.0 - initial release
// ============================================================================
interface toggle_pulse_gen_if #(
  parameter int CNT_W = 8
);
  logic             btn_in;
  logic             t_out;
  logic             btn_db;
  logic [CNT_W-1:0] press_cnt;

  modport master (
    output btn_in,
    input  t_out,
    input  btn_db,
    input  press_cnt
  );

  modport slave (
    input  btn_in,
    output t_out,
    output btn_db,
    output press_cnt
  );
endinterface : toggle_pulse_gen_if
`default_nettype wire

// File: rtl/toggle_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : toggle_pulse_gen
// Purpose  : Converts a raw, bouncing, asynchronous push-button into clean
//            single-cycle toggle-request pulses. Path: 2-FF synchronizer,
//            debounce FSM, optional hold-to-repeat, wrapping pulse counter.
// Ports    : clk           - single clock, rising edge
//            rst           - synchronous active-high reset
//            pb (slave)    - btn_in in; t_out, btn_db, press_cnt out
// Revision : 1.0 - initial release
// ============================================================================
module toggle_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 4,
  parameter int CNT_W           = 8
) (
  input  wire                      clk,
  input  wire                      rst,
  toggle_pulse_gen_if.slave        pb
);

  // Counter widths cover the largest terminal count each counter must hold.
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
  localparam logic [DEB_W-1:0] DEB_ONE    = DEB_W'(1);
  localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    PRESS_CHK   = 3'd1,
    HELD        = 3'd2,
    REPEAT      = 3'd3,
    RELEASE_CHK = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [RPT_W-1:0]  rpt_cnt_q, rpt_cnt_d;
  logic              t_out_q, t_out_d;
  logic              btn_db_q, btn_db_d;
  logic [CNT_W-1:0]  press_cnt_q, press_cnt_d;
  logic              pulse;
  logic              s;

  // The FSM only ever looks at the second synchronizer stage.
  assign s = sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      rpt_cnt_q   <= '0;
      t_out_q     <= 1'b0;
      btn_db_q    <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      sync1_q     <= pb.btn_in;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      rpt_cnt_q   <= rpt_cnt_d;
      t_out_q     <= t_out_d;
      btn_db_q    <= btn_db_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    rpt_cnt_d = rpt_cnt_q;
    btn_db_d  = btn_db_q;
    pulse     = 1'b0;

    case (state_q)
      IDLE: begin
        btn_db_d = 1'b0;
        if (s) begin
          state_d   = PRESS_CHK;
          deb_cnt_d = DEB_ONE;
        end else begin
          deb_cnt_d = '0;
        end
      end

      PRESS_CHK: begin
        if (!s) begin
          // Bounce during press: start over without a pulse.
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = HELD;
          pulse     = 1'b1;
          btn_db_d  = 1'b1;
          rpt_cnt_d = '0;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end

      HELD: begin
        if (!s) begin
          state_d   = RELEASE_CHK;
          deb_cnt_d = DEB_ONE;
        end else if (REPEAT_EN != 0) begin
          if (rpt_cnt_q == DELAY_LAST) begin
            state_d   = REPEAT;
            pulse     = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_ONE;
          end
        end
      end

      REPEAT: begin
        if (!s) begin
          state_d   = RELEASE_CHK;
          deb_cnt_d = DEB_ONE;
        end else if (REPEAT_EN != 0) begin
          if (rpt_cnt_q == RATE_LAST) begin
            pulse     = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_ONE;
          end
        end
      end

      RELEASE_CHK: begin
        if (s) begin
          // Release glitch: the button is still held; restart repeat timing.
          state_d   = HELD;
          rpt_cnt_d = '0;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d   = IDLE;
          btn_db_d  = 1'b0;
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DEB_ONE;
        end
      end

      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
        rpt_cnt_d = '0;
        btn_db_d  = 1'b0;
      end
    endcase
  end

  assign t_out_d     = pulse;
  assign press_cnt_d = pulse ? (press_cnt_q + CNT_ONE) : press_cnt_q;

  assign pb.t_out     = t_out_q;
  assign pb.btn_db    = btn_db_q;
  assign pb.press_cnt = press_cnt_q;

endmodule : toggle_pulse_gen
`default_nettype wire

// File: tb/tb_toggle_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_toggle_pulse_gen
// Purpose  : Directed self-checking bench for toggle_pulse_gen. Two DUTs:
//            u0 (no repeat, 2-bit counter) and u1 (auto-repeat enabled).
//            Edge Ek is the k-th rising edge after btn_in is first driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toggle_pulse_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  toggle_pulse_gen_if #(.CNT_W(2)) if0 ();
  toggle_pulse_gen_if #(.CNT_W(8)) if1 ();

  toggle_pulse_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(8),
    .REPEAT_RATE(4), .CNT_W(2)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .pb  (if0.slave)
  );

  toggle_pulse_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(8),
    .REPEAT_RATE(4), .CNT_W(8)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .pb  (if1.slave)
  );

  always #5 clk = ~clk;

  // Advance past one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    if0.btn_in = 1'b0;
    if1.btn_in = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (if0.t_out !== 1'b0 || if0.btn_db !== 1'b0 || if0.press_cnt !== 2'd0) begin
      n_err++;
      $display("FAIL reset_u0: got t=%b db=%b cnt=%0d, want 0 0 0", if0.t_out, if0.btn_db, if0.press_cnt);
    end
    n_cmp++;
    if (if1.t_out !== 1'b0 || if1.btn_db !== 1'b0 || if1.press_cnt !== 8'd0) begin
      n_err++;
      $display("FAIL reset_u1: got t=%b db=%b cnt=%0d, want 0 0 0", if1.t_out, if1.btn_db, if1.press_cnt);
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    if0.btn_in = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if (if0.t_out !== (k == 5) || if0.btn_db !== (k >= 5)) begin
        n_err++;
        $display("FAIL clean_press E%0d: got t=%b db=%b, want t=%b db=%b", k, if0.t_out, if0.btn_db, (k == 5), (k >= 5));
      end
    end
    if0.btn_in = 1'b0;
    for (int r = 0; r < 10; r++) begin
      tick();
      n_cmp++;
      if (if0.t_out !== 1'b0 || if0.btn_db !== (r < 5)) begin
        n_err++;
        $display("FAIL clean_release R%0d: got t=%b db=%b, want t=0 db=%b", r, if0.t_out, if0.btn_db, (r < 5));
      end
    end
    n_cmp++;
    if (if0.press_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL clean_cnt: got %0d, want 1", if0.press_cnt);
    end
  endtask

  task automatic test_press_bounce();
    do_reset();
    for (int k = 0; k < 20; k++) begin
      if0.btn_in = (k != 2);
      tick();
      n_cmp++;
      if (if0.t_out !== (k == 8) || if0.btn_db !== (k >= 8)) begin
        n_err++;
        $display("FAIL press_bounce E%0d: got t=%b db=%b, want t=%b db=%b", k, if0.t_out, if0.btn_db, (k == 8), (k >= 8));
      end
    end
    if0.btn_in = 1'b0;
    for (int r = 0; r < 10; r++) tick();
    n_cmp++;
    if (if0.press_cnt !== 2'd1 || if0.btn_db !== 1'b0) begin
      n_err++;
      $display("FAIL press_bounce_end: got cnt=%0d db=%b, want cnt=1 db=0", if0.press_cnt, if0.btn_db);
    end
  endtask

  task automatic test_release_bounce();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      if0.btn_in = !(k == 10 || k == 11);
      tick();
      n_cmp++;
      if (if0.t_out !== (k == 5) || if0.btn_db !== (k >= 5)) begin
        n_err++;
        $display("FAIL release_bounce E%0d: got t=%b db=%b, want t=%b db=%b", k, if0.t_out, if0.btn_db, (k == 5), (k >= 5));
      end
    end
    // A full debounce after the glitch shows the FSM went back to HELD.
    if0.btn_in = 1'b0;
    for (int r = 0; r < 10; r++) begin
      tick();
      n_cmp++;
      if (if0.t_out !== 1'b0 || if0.btn_db !== (r < 5)) begin
        n_err++;
        $display("FAIL release_after_glitch R%0d: got t=%b db=%b, want t=0 db=%b", r, if0.t_out, if0.btn_db, (r < 5));
      end
    end
    n_cmp++;
    if (if0.press_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL release_bounce_cnt: got %0d, want 1", if0.press_cnt);
    end
  endtask

  task automatic test_auto_repeat();
    logic exp_t;
    logic exp_db;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      if1.btn_in = (k <= 21);
      tick();
      exp_t  = (k == 5) || (k == 13) || (k == 17) || (k == 21);
      exp_db = (k >= 5) && (k < 27);
      n_cmp++;
      if (if1.t_out !== exp_t || if1.btn_db !== exp_db) begin
        n_err++;
        $display("FAIL auto_repeat E%0d: got t=%b db=%b, want t=%b db=%b", k, if1.t_out, if1.btn_db, exp_t, exp_db);
      end
    end
    n_cmp++;
    if (if1.press_cnt !== 8'd4) begin
      n_err++;
      $display("FAIL auto_repeat_cnt: got %0d, want 4", if1.press_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_t;
    logic exp_db;
    do_reset();
    if0.btn_in = 1'b1;
    for (int k = 0; k < 21; k++) begin
      rst = (k == 7);
      tick();
      if (k == 7) begin
        n_cmp++;
        if (if0.t_out !== 1'b0 || if0.btn_db !== 1'b0 || if0.press_cnt !== 2'd0) begin
          n_err++;
          $display("FAIL reset_mid E7: got t=%b db=%b cnt=%0d, want 0 0 0", if0.t_out, if0.btn_db, if0.press_cnt);
        end
      end else begin
        exp_t  = (k == 5) || (k == 13);
        exp_db = (k == 5) || (k == 6) || (k >= 13);
        n_cmp++;
        if (if0.t_out !== exp_t || if0.btn_db !== exp_db) begin
          n_err++;
          $display("FAIL reset_mid E%0d: got t=%b db=%b, want t=%b db=%b", k, if0.t_out, if0.btn_db, exp_t, exp_db);
        end
      end
    end
    rst = 1'b0;
    n_cmp++;
    if (if0.press_cnt !== 2'd1) begin
      n_err++;
      $display("FAIL reset_mid_cnt: got %0d, want 1", if0.press_cnt);
    end
    if0.btn_in = 1'b0;
    for (int r = 0; r < 10; r++) tick();
  endtask

  task automatic test_wrap();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int p = 0; p < 5; p++) begin
      if0.btn_in = 1'b1;
      for (int k = 0; k < 8; k++) tick();
      if0.btn_in = 1'b0;
      for (int k = 0; k < 8; k++) tick();
      n_cmp++;
      if (if0.press_cnt !== exp_cnt[p]) begin
        n_err++;
        $display("FAIL wrap press%0d: got %0d, want %0d", p, if0.press_cnt, exp_cnt[p]);
      end
    end
  endtask

  initial begin
    if0.btn_in = 1'b0;
    if1.btn_in = 1'b0;
    test_reset();
    test_clean_press();
    test_press_bounce();
    test_release_bounce();
    test_auto_repeat();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_toggle_pulse_gen
`default_nettype wire
